// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and its command sequencer.
package alu_pkg;

  localparam int W = 16;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    TRU  = 3'b001,
    SET0 = 3'b010,
    SET1 = 3'b011,
    SET2 = 3'b100,
    SET3 = 3'b101,
    SUB  = 3'b110,
    RSVD = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Accumulator-style command sequencer: feeds the neighbouring ALU, writes its
// result back into acc rep+1 times and returns the final value.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int W     = alu_pkg::W,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_data,
  input  logic [REP_W-1:0] cmd_rep,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_op,
  input  logic [W-1:0]     alu_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_err,
  output logic [W-1:0]     acc
);

  seq_state_t       state;
  alu_op_t          op_q;
  logic [W-1:0]     data_q;
  logic [REP_W-1:0] cnt;

  // NOTE: every register here is a plain flop, so all of them take the async
  // reset; sequential state is only ever assigned with <= so that reads in the
  // same block see the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      op_q      <= ADD;
      data_q    <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= alu_op_t'(cmd_op);
            data_q <= cmd_data;
            cnt    <= cmd_rep;
            if (alu_op_t'(cmd_op) == RSVD) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_err   <= 1'b1;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          acc <= alu_r;
          if (cnt == '0) begin
            state     <= DONE;
            res_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
          end
        end
        // The spare encoding recovers to IDLE and leaves acc alone.
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: each output gets a default before the conditional override so no
  // latch can be inferred.
  always_comb begin
    cmd_ready = 1'b0;
    alu_a     = acc;
    alu_b     = '0;
    alu_op    = TRU;
    res_data  = acc;
    if (state == IDLE) cmd_ready = 1'b1;
    if (state == EXEC) begin
      alu_b  = data_q;
      alu_op = op_q;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU closing the loop.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [3:0]  cmd_rep;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_r;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;
  logic [15:0] acc;

  int checks   = 0;
  int failures = 0;

  alu_sequencer #(.W(16), .REP_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_rep(cmd_rep),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .acc(acc)
  );

  always #5 clk = ~clk;

  // Reference ALU: ADD, pass-through, load constant n, SUB.
  always_comb begin
    alu_r = alu_a;
    case (alu_op)
      3'b000: alu_r = alu_a + alu_b;
      3'b001: alu_r = alu_a;
      3'b010: alu_r = 16'h0000;
      3'b011: alu_r = 16'h0001;
      3'b100: alu_r = 16'h0002;
      3'b101: alu_r = 16'h0003;
      3'b110: alu_r = alu_a - alu_b;
      default: alu_r = alu_a;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command in IDLE; returns one step after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [15:0] data, input logic [3:0] rep);
    check("send_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_rep   = rep;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Expect n EXEC cycles driving op/b, then a completed result.
  task automatic expect_run(input string tag, input logic [2:0] op, input logic [15:0] b,
                            input int n, input logic [15:0] res);
    for (int i = 0; i < n; i++) begin
      check({tag, "_alu_op"}, alu_op, op);
      check({tag, "_alu_b"}, alu_b, b);
      check({tag, "_busy_ready"}, cmd_ready, 1'b0);
      check({tag, "_early_valid"}, res_valid, 1'b0);
      tick();
    end
    check({tag, "_res_valid"}, res_valid, 1'b1);
    check({tag, "_res_data"}, res_data, res);
    check({tag, "_res_err"}, res_err, 1'b0);
    check({tag, "_done_alu_op"}, alu_op, 3'b001);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("consume_valid", res_valid, 1'b0);
    check("consume_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_data = 16'h0;
    cmd_rep = 4'h0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_acc", acc, 16'h0000);
    check("rst_valid", res_valid, 1'b0);
    check("rst_err", res_err, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_alu_op", alu_op, 3'b001);

    // Single ADD, then four back-to-back ADD iterations.
    send(3'b000, 16'h0005, 4'd0);
    expect_run("add1", 3'b000, 16'h0005, 1, 16'h0005);
    consume();
    send(3'b000, 16'h0003, 4'd3);
    expect_run("add4", 3'b000, 16'h0003, 4, 16'h0011);
    consume();

    // Clear, wrap below zero, then repeated SET2.
    send(3'b010, 16'h0000, 4'd0);
    expect_run("set0", 3'b010, 16'h0000, 1, 16'h0000);
    consume();
    send(3'b110, 16'h0001, 4'd0);
    expect_run("sub_wrap", 3'b110, 16'h0001, 1, 16'hFFFF);
    consume();
    send(3'b100, 16'h00AA, 4'd7);
    expect_run("set2x8", 3'b100, 16'h00AA, 8, 16'h0002);
    consume();
    send(3'b000, 16'h1232, 4'd0);
    expect_run("load1234", 3'b000, 16'h1232, 1, 16'h1234);
    consume();

    // Reserved opcode: immediate error result held while res_ready is low.
    send(3'b111, 16'hBEEF, 4'd5);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_data = 16'h0001; cmd_rep = 4'd0;
    for (int i = 0; i < 3; i++) begin
      check("rsvd_valid", res_valid, 1'b1);
      check("rsvd_err", res_err, 1'b1);
      check("rsvd_data", res_data, 16'h1234);
      check("rsvd_ready", cmd_ready, 1'b0);
      check("rsvd_alu_b", alu_b, 16'h0000);
      tick();
    end
    cmd_valid = 1'b0;
    consume();
    check("rsvd_err_clr", res_err, 1'b0);
    check("rsvd_acc_kept", acc, 16'h1234);
    tick();
    check("rsvd_no_accept", cmd_ready, 1'b1);
    check("rsvd_acc_idle", acc, 16'h1234);

    // Asynchronous reset while idle, observed before the next edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_acc", acc, 16'h0000);
    check("async_rst_valid", res_valid, 1'b0);
    check("async_rst_err", res_err, 1'b0);
    check("async_rst_ready", cmd_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    // Reset on the fifth EXEC cycle of a 16-iteration ADD.
    send(3'b000, 16'h0001, 4'd15);
    for (int i = 0; i < 4; i++) begin
      check("abort_alu_op", alu_op, 3'b000);
      tick();
    end
    check("abort_acc_pre", acc, 16'h0004);
    rst = 1'b1;
    #1;
    check("abort_acc", acc, 16'h0000);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_alu_op_idle", alu_op, 3'b001);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_no_valid", res_valid, 1'b0);
      check("abort_acc_zero", acc, 16'h0000);
      tick();
    end
    send(3'b000, 16'h0007, 4'd1);
    expect_run("post_abort", 3'b000, 16'h0007, 2, 16'h000E);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
